grev_sched: RTL

GREV_SCHED -- requirements
Module: grev_sched

---
 rtl/grev_sched_pkg.sv | 16 +
 rtl/grev_rr_arb.sv | 50 +++++
 rtl/grev_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/grev_sched_pkg.sv
// grev_sched_pkg: shared definitions for the GREV request scheduler.
//   state_t  - scheduler FSM states (IDLE, WAIT, RESP)
//   ENG_LAT  - cycles from eng_start to eng_done of the shared GREV engine
//   DEF_TMO  - default cycle budget for the engine before a timeout is declared
package grev_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned ENG_LAT = 6;
   localparam int unsigned DEF_TMO = 8;

endpackage

// File: rtl/grev_rr_arb.sv
// grev_rr_arb: round-robin arbiter over NREQ request lines.
//   clock, reset - clock and synchronous active-high reset
//   req          - request bits, one per requester
//   advance      - strobe: the current winner was accepted, move the pointer
//   grant        - one-hot winner (all zero when no request is present)
//   grant_idx    - encoded index of the winner
// The pointer holds the last accepted index; the search begins one past it.
// It resets to NREQ-1 so requester 0 has priority first.
module grev_rr_arb
   import grev_sched_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic                      advance,
   output logic [NREQ-1:0]           grant,
   output logic [$clog2(NREQ)-1:0]   grant_idx
);

   localparam int unsigned IDW = $clog2(NREQ);

   logic [IDW-1:0] last;
   logic [IDW-1:0] idx;
   logic           found;

   always_ff @(posedge clock) begin
      if (reset)
         last <= IDW'(NREQ - 1);
      else if (advance)
         last <= grant_idx;
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = IDW'((32'(last) + off) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/grev_sched.sv
// grev_sched: arbitrates NREQ requesters onto one shared iterative GREV engine.
//   clock, reset          - clock; synchronous active-high reset (shared with engine)
//   req_valid/req_ready   - per-requester handshake; at most one ready bit high
//   req_rs1/rs2/tag       - packed per-requester operand, GREV control and tag
//   resp_valid/resp_ready - result handshake; outputs held until consumed
//   resp_id/tag/rd        - owner index, owner tag and result value
//   eng_start             - one-cycle start pulse, with eng_rs1/eng_rs2 operands
//   eng_rd/eng_busy/eng_done - engine result and status
//   err                   - sticky: engine timeout or eng_done outside WAIT
// rs2 == 0 is an identity permutation and bypasses the engine entirely.
module grev_sched
   import grev_sched_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned TAGW = 4,
   parameter int unsigned TMO  = DEF_TMO
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*32-1:0]      req_rs1,
   input  logic [NREQ*5-1:0]       req_rs2,
   input  logic [NREQ*TAGW-1:0]    req_tag,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [$clog2(NREQ)-1:0] resp_id,
   output logic [TAGW-1:0]         resp_tag,
   output logic [31:0]             resp_rd,
   output logic                    eng_start,
   output logic [31:0]             eng_rs1,
   output logic [4:0]              eng_rs2,
   input  logic [31:0]             eng_rd,
   input  logic                    eng_busy,
   input  logic                    eng_done,
   output logic                    err
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   state_t            state, state_nx;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    win_idx;
   logic [31:0]       win_rs1;
   logic [4:0]        win_rs2;
   logic [TAGW-1:0]   win_tag;
   logic              can_grant;
   logic              accept;
   logic              bypass;
   logic              tmo_hit;
   logic [CW-1:0]     tmo_cnt;

   grev_rr_arb #(.NREQ(NREQ)) u_arb (
      .clock     (clock),
      .reset     (reset),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (win_idx)
   );

   // Gating on reset keeps req_ready and eng_start low during the reset cycle.
   assign can_grant  = (state == IDLE) && !reset && !eng_busy;
   assign req_ready  = grant & {NREQ{can_grant}};
   assign accept     = |(req_valid & req_ready);
   assign bypass     = (win_rs2 == 5'd0);
   assign tmo_hit    = (tmo_cnt == TMO_LAST);
   assign eng_rs1    = win_rs1;
   assign eng_rs2    = win_rs2;
   assign resp_valid = (state == RESP);

   always_comb begin
      win_rs1 = '0;
      win_rs2 = '0;
      win_tag = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_rs1 = req_rs1[i*32 +: 32];
            win_rs2 = req_rs2[i*5 +: 5];
            win_tag = req_tag[i*TAGW +: TAGW];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      eng_start = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bypass) begin
                  state_nx = RESP;
               end else begin
                  state_nx  = WAIT;
                  eng_start = 1'b1;
               end
            end
         end
         WAIT: begin
            if (eng_done || tmo_hit)
               state_nx = RESP;
         end
         RESP: begin
            if (resp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // tmo_cnt counts completed WAIT cycles; the TMO-th WAIT cycle without
   // eng_done ends the wait with a zero result.
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_rd  <= '0;
         resp_id  <= '0;
         resp_tag <= '0;
         err      <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         if (accept) begin
            resp_id  <= win_idx;
            resp_tag <= win_tag;
            tmo_cnt  <= '0;
            if (bypass)
               resp_rd <= win_rs1;
         end
         if (state == WAIT) begin
            if (eng_done) begin
               resp_rd <= eng_rd;
            end else if (tmo_hit) begin
               resp_rd <= '0;
               err     <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else if (eng_done) begin
            err <= 1'b1;
         end
      end
   end

endmodule
